// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with variable step, parallel load and wrap/saturate
// boundary handling; wrap and sat are registered one-cycle flags aligned with out_o.
module updown_counter_param #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned MOD    = 16,
   parameter int unsigned STEP_W = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              load_i,
   input  logic [WIDTH-1:0]  load_val_i,
   input  logic [STEP_W-1:0] step_i,
   input  logic              down_i,
   input  logic              sat_mode_i,
   output logic [WIDTH-1:0]  out_o,
   output logic              wrap_o,
   output logic              sat_o
);

   localparam longint unsigned ModL   = longint'(MOD);
   localparam longint unsigned RangeL = longint'(1) << WIDTH;
   localparam longint unsigned StepL  = (longint'(1) << STEP_W) - 1;

   // Parameter legality is checked at elaboration so a bad instance never builds.
   if (WIDTH < 1 || WIDTH > 62) begin : g_bad_width
      $error("updown_counter_param: WIDTH must be in 1..62");
   end
   if (ModL < 2 || ModL > RangeL) begin : g_bad_mod
      $error("updown_counter_param: MOD must satisfy 2 <= MOD <= 2^WIDTH");
   end
   if (STEP_W < 1 || StepL > ModL - 1) begin : g_bad_step
      $error("updown_counter_param: STEP_W must satisfy 2^STEP_W - 1 <= MOD - 1");
   end

   localparam logic [WIDTH:0] ModW = (WIDTH+1)'(MOD);
   localparam logic [WIDTH:0] MaxW = (WIDTH+1)'(MOD - 1);

   logic [WIDTH-1:0] out_q, out_d;
   logic             wrap_q, wrap_d;
   logic             sat_q, sat_d;

   logic [WIDTH:0] cnt_ext;
   logic [WIDTH:0] step_ext;
   logic [WIDTH:0] load_ext;
   logic [WIDTH:0] sum;
   logic [WIDTH:0] sum_wrap;
   logic [WIDTH:0] diff;
   logic [WIDTH:0] diff_wrap;
   logic           up_over;
   logic           down_under;

   // All boundary arithmetic is one bit wider so MOD = 2^WIDTH needs no special case.
   always_comb begin
      cnt_ext    = {1'b0, out_q};
      step_ext   = (WIDTH+1)'(step_i);
      load_ext   = {1'b0, load_val_i};
      sum        = cnt_ext + step_ext;
      sum_wrap   = sum - ModW;
      diff       = cnt_ext - step_ext;
      diff_wrap  = cnt_ext + ModW - step_ext;
      up_over    = (sum >= ModW);
      down_under = (step_ext > cnt_ext);
   end

   always_comb begin
      out_d  = out_q;
      wrap_d = 1'b0;
      sat_d  = 1'b0;
      if (load_i) begin
         if (load_ext < ModW) begin
            out_d = load_val_i;
         end else begin
            out_d = MaxW[WIDTH-1:0];
            sat_d = 1'b1;
         end
      end else if (en_i && (step_i != '0)) begin
         if (!down_i) begin
            if (!up_over) begin
               out_d = sum[WIDTH-1:0];
            end else if (!sat_mode_i) begin
               out_d  = sum_wrap[WIDTH-1:0];
               wrap_d = 1'b1;
            end else begin
               out_d = MaxW[WIDTH-1:0];
               sat_d = 1'b1;
            end
         end else begin
            if (!down_under) begin
               out_d = diff[WIDTH-1:0];
            end else if (!sat_mode_i) begin
               out_d  = diff_wrap[WIDTH-1:0];
               wrap_d = 1'b1;
            end else begin
               out_d = '0;
               sat_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_q  <= '0;
         wrap_q <= 1'b0;
         sat_q  <= 1'b0;
      end else begin
         out_q  <= out_d;
         wrap_q <= wrap_d;
         sat_q  <= sat_d;
      end
   end

   assign out_o  = out_q;
   assign wrap_o = wrap_q;
   assign sat_o  = sat_q;

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised synchronous up/down counter. It is the successor to the fixed 4-bit step-1/step-2 counter. It adds configurable width and modulus, a variable step amount, count enable, parallel load, and a selectable wrap or saturate mode at the boundaries. Registered single-cycle wrap and saturate flags let it drive cascaded stages and timer logic in the lab designs.

Parameters:
WIDTH, 4, counter width in bits
MOD, 16, count modulus; legal values are 0..MOD-1; requires 2 <= MOD <= 2^WIDTH
STEP_W, 2, width of the step input; requires 2^STEP_W - 1 <= MOD - 1

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, synchronous, active-high
en  input  1  count enable
load  input  1  parallel load strobe
load_val  input  WIDTH  value to load
step  input  STEP_W  increment/decrement amount; 0 means hold
down  input  1  0 = count up, 1 = count down
sat_mode  input  1  0 = wrap modulo MOD, 1 = saturate at 0 / MOD-1
out  output  WIDTH  counter value, registered
wrap  output  1  one-cycle pulse: the last update wrapped around
sat  output  1  one-cycle pulse: the last update was clamped

Behaviour:
- Single clock domain. All outputs are registered. The effect of an input appears on out one cycle after the sampling edge.
- Reset: when rst=1 at an edge, out=0, wrap=0 and sat=0, regardless of all other inputs. A reset issued mid-count takes effect immediately at that edge.
- Priority at each edge: rst > load > (en and step != 0) > hold.
- Load:
  - out <= load_val if load_val < MOD, otherwise out <= MOD-1.
  - wrap=0. sat=1 only if load_val was clamped, else sat=0.
  - en, step, down and sat_mode are ignored during a load.
- Hold (en=0, or step=0, with no load): out is unchanged; wrap=0, sat=0.
- Count up (down=0): compute s = out + step at WIDTH+1 bits, so no overflow is lost.
  - s < MOD: out <= s; flags 0.
  - s >= MOD, sat_mode=0: out <= s - MOD; wrap=1.
  - s >= MOD, sat_mode=1: out <= MOD-1; sat=1.
  - Already at MOD-1 with sat_mode=1 and step>0: stays at MOD-1 and sat=1 again. The flag repeats every clamped cycle.
- Count down (down=1):
  - step <= out: out <= out - step; flags 0.
  - step > out, sat_mode=0: out <= out + MOD - step; wrap=1.
  - step > out, sat_mode=1: out <= 0; sat=1.
- wrap and sat are never both 1 in the same cycle. Each flag is high for exactly the cycle in which the corresponding out value is presented.
- Changing down, sat_mode or step between cycles is legal. Each edge uses only the values sampled at that edge.
- No internal state exists beyond out, wrap and sat. No FSM is needed beyond the priority decode above.
- Arithmetic widths:
  - All comparisons against MOD use WIDTH+1 bits, so MOD = 2^WIDTH is handled.
  - step is zero-extended.
- Elaboration must fail if a parameter constraint is violated.

Test Plan:
All scenarios use WIDTH=4, MOD=10, STEP_W=2.
1. Reset: rst=1 with en=1, step=3, load=1 -> next cycle out=0, wrap=0, sat=0. rst=0 with en=1, step=1, down=0 -> out goes 1,2,...,9, then 0 with wrap=1 on the cycle out=0.
2. Step and wrap up: load 8, then step=3, down=0, sat_mode=0 -> out=1, wrap=1. Next step=2 -> out=3, wrap=0.
3. Wrap down: load 1, step=3, down=1, sat_mode=0 -> out=8, wrap=1. Next -> out=5, wrap=0.
4. Saturate: load 8, step=3, up, sat_mode=1 -> out=9, sat=1; next cycle out=9, sat=1. Switch to down, step=3 -> 6, 3, 0, then 0 with sat=1.
5. Load priority and clamp: load=1, load_val=13, en=1, step=2 -> out=9, sat=1, wrap=0. Then load_val=4 -> out=4, sat=0.
6. Hold and mid-operation reset: en=0 or step=0 for 3 cycles -> out unchanged, flags 0. rst asserted for one cycle mid-count at out=7 -> out=0 next cycle, and counting resumes from 0.
